// File: rtl/scan_chain_cfg.sv
// Serial configuration scan chain with a shadow register, parallel status capture,
// a saturating shift counter, a sticky load-error flag and a one-cycle update strobe.
module scan_chain_cfg #(
   parameter int unsigned           WIDTH   = 16,
   parameter logic [WIDTH-1:0]      RST_VAL = {WIDTH{1'b0}},
   localparam int unsigned          CW      = $clog2(WIDTH + 1)
) (
   input  logic             SC_CLK,
   input  logic             RST,
   input  logic             SC_EN,
   input  logic             SC_DIN,
   input  logic             SC_CAPTURE,
   input  logic [WIDTH-1:0] SC_STATUS,
   input  logic             SC_LATCH,
   output logic             SC_DOUT,
   output logic [WIDTH-1:0] S,
   output logic [CW-1:0]    SC_CNT,
   output logic             SC_ERR,
   output logic             SC_UPD
);

   localparam logic [CW-1:0] CntFull = CW'(WIDTH);

   logic [WIDTH-1:0] r_shift;
   logic [WIDTH-1:0] r_shadow;
   logic [CW-1:0]    r_cnt;
   logic             r_err;
   logic             r_upd;
   logic             w_full;

   assign w_full = (r_cnt == CntFull);

   // Priority: reset, capture, latch, shift; lower requests are dropped that cycle.
   always_ff @(posedge SC_CLK) begin
      if (RST) begin
         r_shift  <= RST_VAL;
         r_shadow <= RST_VAL;
         r_cnt    <= '0;
         r_err    <= 1'b0;
         r_upd    <= 1'b0;
      end else begin
         r_upd <= 1'b0;
         if (SC_CAPTURE) begin
            r_shift <= SC_STATUS;
            r_cnt   <= '0;
         end else if (SC_LATCH) begin
            if (w_full) begin
               r_shadow <= r_shift;
               r_cnt    <= '0;
               r_err    <= 1'b0;
               r_upd    <= 1'b1;
            end else begin
               r_err <= 1'b1;
            end
         end else if (SC_EN) begin
            r_shift <= {r_shift[WIDTH-2:0], SC_DIN};
            if (!w_full) begin
               r_cnt <= r_cnt + CW'(1);
            end
         end
      end
   end

   assign SC_DOUT = r_shift[WIDTH-1];
   assign S       = r_shadow;
   assign SC_CNT  = r_cnt;
   assign SC_ERR  = r_err;
   assign SC_UPD  = r_upd;

endmodule

// File: tb/tb_scan_chain_cfg.sv
// Directed bench for scan_chain_cfg at WIDTH=4 with hand-computed expectations.
module tb_scan_chain_cfg;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned CW    = $clog2(WIDTH + 1);

   logic             clk;
   logic             rst;
   logic             en;
   logic             din;
   logic             cap;
   logic [WIDTH-1:0] status;
   logic             lat;
   logic             dout;
   logic [WIDTH-1:0] s;
   logic [CW-1:0]    cnt;
   logic             err;
   logic             upd;

   int checks   = 0;
   int failures = 0;

   scan_chain_cfg #(
      .WIDTH   (WIDTH),
      .RST_VAL ('0)
   ) u_dut (
      .SC_CLK     (clk),
      .RST        (rst),
      .SC_EN      (en),
      .SC_DIN     (din),
      .SC_CAPTURE (cap),
      .SC_STATUS  (status),
      .SC_LATCH   (lat),
      .SC_DOUT    (dout),
      .S          (s),
      .SC_CNT     (cnt),
      .SC_ERR     (err),
      .SC_UPD     (upd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle with the given inputs; outputs are sampled 1ns after the edge.
   task automatic step(input logic r, input logic e, input logic d, input logic c,
                       input logic l);
      rst = r;
      en  = e;
      din = d;
      cap = c;
      lat = l;
      @(posedge clk);
      #1;
      rst = 1'b0;
      en  = 1'b0;
      din = 1'b0;
      cap = 1'b0;
      lat = 1'b0;
   endtask

   task automatic shift(input logic d);
      step(1'b0, 1'b1, d, 1'b0, 1'b0);
   endtask

   task automatic latch();
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      rst    = 1'b1;
      en     = 1'b0;
      din    = 1'b0;
      cap    = 1'b0;
      lat    = 1'b0;
      status = '0;
      #2;

      // Reset
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst_s", 8'(s), 8'h0);
      chk("rst_cnt", 8'(cnt), 8'h0);
      chk("rst_err", 8'(err), 8'h0);
      chk("rst_upd", 8'(upd), 8'h0);
      chk("rst_dout", 8'(dout), 8'h0);

      // Normal load 1011
      shift(1'b1);
      shift(1'b0);
      shift(1'b1);
      shift(1'b1);
      chk("norm_cnt_full", 8'(cnt), 8'h4);
      latch();
      chk("norm_s", 8'(s), 8'hB);
      chk("norm_cnt", 8'(cnt), 8'h0);
      chk("norm_err", 8'(err), 8'h0);
      chk("norm_upd_hi", 8'(upd), 8'h1);

      // Back-to-back latch rejected
      latch();
      chk("b2b_upd_lo", 8'(upd), 8'h0);
      chk("b2b_err", 8'(err), 8'h1);
      chk("b2b_s", 8'(s), 8'hB);

      // Short load with an idle gap, then completion
      shift(1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("gap_cnt", 8'(cnt), 8'h1);
      shift(1'b1);
      shift(1'b0);
      latch();
      chk("short_s", 8'(s), 8'hB);
      chk("short_err", 8'(err), 8'h1);
      chk("short_cnt", 8'(cnt), 8'h3);
      chk("short_upd", 8'(upd), 8'h0);
      shift(1'b1);
      latch();
      chk("short2_s", 8'(s), 8'h5);
      chk("short2_err", 8'(err), 8'h0);
      chk("short2_upd", 8'(upd), 8'h1);

      // Readback of status 0110
      status = 4'b0110;
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("cap_dout", 8'(dout), 8'h0);
      chk("cap_cnt", 8'(cnt), 8'h0);
      shift(1'b1);
      chk("rb_dout1", 8'(dout), 8'h1);
      shift(1'b1);
      chk("rb_dout2", 8'(dout), 8'h1);
      shift(1'b1);
      chk("rb_dout3", 8'(dout), 8'h0);
      shift(1'b1);
      chk("rb_dout4", 8'(dout), 8'h1);
      chk("rb_cnt", 8'(cnt), 8'h4);
      latch();
      chk("rb_s", 8'(s), 8'hF);

      // Capture + latch: capture wins, S and error untouched
      shift(1'b1);
      shift(1'b0);
      shift(1'b0);
      shift(1'b1);
      status = 4'b0110;
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("caplat_s", 8'(s), 8'hF);
      chk("caplat_err", 8'(err), 8'h0);
      chk("caplat_cnt", 8'(cnt), 8'h0);
      chk("caplat_dout", 8'(dout), 8'h0);
      chk("caplat_upd", 8'(upd), 8'h0);

      // Latch + enable when full: no shift, pre-edge word latched
      shift(1'b0);
      shift(1'b1);
      shift(1'b0);
      shift(1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("laten_s", 8'(s), 8'h4);
      chk("laten_dout", 8'(dout), 8'h0);
      chk("laten_cnt", 8'(cnt), 8'h0);

      // Overshift: last four of 1,1,0,0,1,0
      shift(1'b1);
      shift(1'b1);
      shift(1'b0);
      shift(1'b0);
      shift(1'b1);
      shift(1'b0);
      chk("over_cnt_sat", 8'(cnt), 8'h4);
      latch();
      chk("over_s", 8'(s), 8'h2);
      chk("over_err", 8'(err), 8'h0);

      // Mid-load reset discards the partial load
      shift(1'b1);
      shift(1'b1);
      chk("mid_cnt", 8'(cnt), 8'h2);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("mid_rst_cnt", 8'(cnt), 8'h0);
      chk("mid_rst_s", 8'(s), 8'h0);
      latch();
      chk("mid_lat_err", 8'(err), 8'h1);
      chk("mid_lat_s", 8'(s), 8'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
